sum_decomposer: RTL and testbench
=================================

SUM_DECOMPOSER -- requirements
Module: sum_decomposer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal values 2, 4 or 8.
REQ-003 SHALL have parameter CNT_W, default 16, completed-transaction counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  input pair {in_c, in_a} is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts the input pair this cycle.
REQ-008 SHALL have port in_c  input  WIDTH  sum operand (c of c = a + b).
REQ-009 SHALL have port in_a  input  WIDTH  known addend a.
REQ-010 SHALL have port out_valid  output  1  head result is valid.
REQ-011 SHALL have port out_ready  input  1  downstream takes the head result.
REQ-012 SHALL have port out_b  output  WIDTH  recovered addend b = c - a.
REQ-013 SHALL have port out_borrow  output  1  set when a > c (unsigned), i.e. b wrapped.
REQ-014 SHALL have port done_cnt  output  CNT_W  count of results popped since reset.

Function
REQ-015 SHALL accept an input when in_valid && in_ready at posedge clk (push).
REQ-016 SHALL compute b = (in_c - in_a) mod 2^WIDTH and borrow = (in_a > in_c), and store both as one buffer entry on push.
REQ-017 SHALL drive in_ready = !full, from registered state only; no combinational path from out_ready to in_ready.
REQ-018 SHALL drive out_valid = !empty; out_b/out_borrow SHALL reflect the oldest entry and stay stable while out_valid && !out_ready.
REQ-019 SHALL pop the head entry when out_valid && out_ready at posedge clk.
REQ-020 SHALL have latency 1: a pair pushed at edge N into an empty buffer is visible on out_* after edge N.
REQ-021 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve FIFO order.
REQ-022 SHALL, when full, hold in_ready low; a pop at edge N makes in_ready high after edge N.
REQ-023 SHALL, when empty, ignore out_ready; no pop, no count change.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; occupancy tracked with a DEPTH+1-state counter (0..DEPTH).
REQ-025 SHALL increment done_cnt by 1 per pop, saturating at 2^CNT_W-1 (no wrap).
REQ-026 SHALL treat in_c/in_a as don't-care when in_valid is low; in_valid dropping without handshake is legal.

Reset
REQ-027 SHALL, on rst_n low, immediately clear pointers, occupancy and done_cnt regardless of clk.
REQ-028 SHALL hold outputs during reset at: in_ready=1, out_valid=0, out_b=0, out_borrow=0, done_cnt=0.
REQ-029 SHALL discard all buffered entries on reset asserted mid-operation; first cycle after deassertion behaves as fresh empty state.
REQ-030 SHALL leave buffer data storage unreset; only control and output-visible state reset.

Structure
REQ-031 SHALL take WIDTH default, CNT_W default and the entry typedef {b, borrow} from shared package sum_pkg.
REQ-032 SHALL instantiate one sub-module sum_fifo (parameterised entry type, DEPTH) for buffering; subtraction stays in sum_decomposer.
REQ-033 SHALL use always_ff for all registers and always_comb for next-state/subtract logic; no procedural assign/deassign.

Verification
REQ-034 SHALL cover: c=8'd12, a=8'd5, out_ready=1 -> one cycle later out_valid=1, out_b=7, out_borrow=0, done_cnt=1 after pop.
REQ-035 SHALL cover: c=8'd3, a=8'd10 -> out_b=8'hF9, out_borrow=1.
REQ-036 SHALL cover: out_ready=0, push 3 pairs with DEPTH=2 -> only first 2 accepted, in_ready=0, 3rd held; release out_ready -> results in order, 3rd accepted after first pop.
REQ-037 SHALL cover: buffer holding 1 entry, push and pop same edge for 10 cycles -> occupancy stays 1, outputs in order, done_cnt=10.
REQ-038 SHALL cover: rst_n low mid-clock with 2 entries buffered -> out_valid=0, in_ready=1, done_cnt=0 immediately, before next edge.
REQ-039 SHALL cover: CNT_W=4, 20 pops -> done_cnt saturates at 15.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared widths and the buffered result entry for the sum decomposer.
package sum_pkg;

    localparam int SUM_WIDTH = 8;
    localparam int SUM_CNT_W = 16;

    // One buffered result: recovered addend plus its wrap flag.
    typedef struct packed {
        logic [SUM_WIDTH-1:0] b;
        logic                 borrow;
    } sum_entry_t;

endpackage

// File: rtl/sum_fifo.sv
// Small synchronous FIFO of an arbitrary packed entry type, DEPTH a power of two.
module sum_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_wdata,
    input  logic i_pop,
    output T     o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_wr;
    logic            w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];

    // Storage is intentionally left unreset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sum_decomposer.sv
// Recovers b = c - a (mod 2^WIDTH) with a borrow flag, buffers results and counts pops.
module sum_decomposer
    import sum_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = SUM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_borrow,
    output logic [CNT_W-1:0] done_cnt
);

    generate
        if (WIDTH != SUM_WIDTH || !(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_param
            $error("sum_decomposer: WIDTH must match sum_pkg entry width, DEPTH must be 2, 4 or 8");
        end
    endgenerate

    sum_entry_t       w_entry;
    sum_entry_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_done_cnt;

    always_comb begin
        w_entry        = '0;
        w_entry.b      = in_c - in_a;
        w_entry.borrow = (in_a > in_c);
    end

    assign w_push = in_valid && !w_full;
    assign w_pop  = !w_empty && out_ready;

    sum_fifo #(
        .T     (sum_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    // Mask the unreset storage so outputs read zero whenever nothing is buffered.
    assign out_b      = w_empty ? '0 : w_head.b;
    assign out_borrow = w_empty ? 1'b0 : w_head.borrow;
    assign done_cnt   = r_done_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (w_pop && (r_done_cnt != '1)) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sum_decomposer.sv
// Randomized self-checking bench for sum_decomposer against a queue-based model.
module tb_sum_decomposer;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [7:0]  in_c, in_a;
    logic        in_ready, out_valid, out_borrow;
    logic [7:0]  out_b;
    logic [15:0] done_cnt;

    logic        s_in_valid, s_out_ready;
    logic [7:0]  s_in_c, s_in_a;
    logic        s_in_ready, s_out_valid, s_out_borrow;
    logic [7:0]  s_out_b;
    logic [3:0]  s_done_cnt;

    int checks = 0;
    int errors = 0;

    // Model: each entry stores (b << 1) | borrow, computed with integer arithmetic.
    int q[$];
    int m_cnt;

    sum_decomposer #(.WIDTH(8), .DEPTH(D), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_c(in_c), .in_a(in_a), .out_valid(out_valid), .out_ready(out_ready),
        .out_b(out_b), .out_borrow(out_borrow), .done_cnt(done_cnt)
    );

    sum_decomposer #(.WIDTH(8), .DEPTH(D), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_c(s_in_c), .in_a(s_in_a), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_b(s_out_b), .out_borrow(s_out_borrow), .done_cnt(s_done_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic int enc(input int c, input int a);
        return (((c - a + 256) % 256) << 1) | ((a > c) ? 1 : 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_cnt <= 0;
        end else begin
            automatic bit do_pop  = (q.size() > 0) && out_ready;
            automatic bit do_push = in_valid && (q.size() < D);
            if (do_pop) begin
                void'(q.pop_front());
                if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            end
            if (do_push) q.push_back(enc(int'(in_c), int'(in_a)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_c = '0; in_a = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_c = '0; s_in_a = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_c = '0; in_a = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_c = '0; s_in_a = '0;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reset_out_b got %h want 00", out_b); end
        checks++; if (out_borrow !== 1'b0) begin errors++; $display("FAIL reset_out_borrow got %b want 0", out_borrow); end
        checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt got %0d want 0", done_cnt); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1'b1; in_c = 8'd12; in_a = 8'd5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        checks++; if (out_b !== 8'd7) begin errors++; $display("FAIL basic_out_b got %0d want 7", out_b); end
        checks++; if (out_borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b want 0", out_borrow); end
        checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL basic_cnt_before got %0d want 0", done_cnt); end
        tick();
        checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt_after got %0d want 1", done_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b want 0", out_valid); end
    endtask

    task automatic test_borrow();
        do_reset();
        in_valid = 1'b1; in_c = 8'd3; in_a = 8'd10; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_b !== 8'hF9) begin errors++; $display("FAIL borrow_out_b got %h want f9", out_b); end
        checks++; if (out_borrow !== 1'b1) begin errors++; $display("FAIL borrow_flag got %b want 1", out_borrow); end
        tick();
        checks++; if (out_b !== 8'hF9 || out_valid !== 1'b1) begin errors++; $display("FAIL borrow_hold got %h/%b want f9/1", out_b, out_valid); end
    endtask

    task automatic test_full();
        logic [7:0] pc [3];
        logic [7:0] pa [3];
        logic [7:0] eb [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pc[i] = 8'($urandom); pa[i] = 8'($urandom);
            eb[i] = 8'((int'(pc[i]) - int'(pa[i]) + 256) % 256);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_c = pc[0]; in_a = pa[0];
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_one got %b want 1", in_ready); end
        in_c = pc[1]; in_a = pa[1];
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_two got %b want 0", in_ready); end
        in_c = pc[2]; in_a = pa[2];
        repeat (2) tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_held got rdy %b vld %b want 0 1", in_ready, out_valid); end
        checks++; if (out_b !== eb[0]) begin errors++; $display("FAIL full_head0 got %h want %h", out_b, eb[0]); end
        checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL full_cnt0 got %0d want 0", done_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b want 1", in_ready); end
        checks++; if (out_b !== eb[1]) begin errors++; $display("FAIL full_head1 got %h want %h", out_b, eb[1]); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_b !== eb[2] || out_valid !== 1'b1) begin errors++; $display("FAIL full_head2 got %h/%b want %h/1", out_b, out_valid, eb[2]); end
        checks++; if (done_cnt !== 16'd2) begin errors++; $display("FAIL full_cnt2 got %0d want 2", done_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0 || done_cnt !== 16'd3) begin errors++; $display("FAIL full_drain got vld %b cnt %0d want 0 3", out_valid, done_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_c = 8'($urandom); in_a = 8'($urandom); out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_c = 8'($urandom); in_a = 8'($urandom);
            checks++;
            if (q.size() != 1 || {out_b, out_borrow} !== 9'(q[0])) begin
                errors++; $display("FAIL b2b_head[%0d] got %h/%b want %h", i, out_b, out_borrow, q.size() > 0 ? q[0] : -1);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_occ[%0d] got vld %b rdy %b want 1 1", i, out_valid, in_ready);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        checks++; if (done_cnt !== 16'd10) begin errors++; $display("FAIL b2b_cnt got %0d want 10", done_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_c = 8'($urandom); in_a = 8'($urandom);
            tick();
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < D) ||
                {out_b, out_borrow} !== ((q.size() > 0) ? 9'(q[0]) : 9'd0) ||
                done_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand[%0d] got vld %b rdy %b b %h br %b cnt %0d want vld %b rdy %b entry %h cnt %0d",
                         i, out_valid, in_ready, out_b, out_borrow, done_cnt,
                         q.size() > 0, q.size() < D, (q.size() > 0) ? q[0] : 0, m_cnt);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_c = 8'd50; in_a = 8'd20;
        tick();
        out_ready = 1'b1; in_c = 8'd60; in_a = 8'd70;
        tick();
        out_ready = 1'b0; in_c = 8'd9; in_a = 8'd9;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || done_cnt !== 16'd1) begin
            errors++; $display("FAIL rmid_pre got vld %b rdy %b cnt %0d want 1 0 1", out_valid, in_ready, done_cnt);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", in_ready); end
        checks++; if (done_cnt !== 16'd0 || out_b !== 8'd0) begin errors++; $display("FAIL rmid_cnt got %0d b %h want 0 00", done_cnt, out_b); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_fresh got vld %b rdy %b want 0 1", out_valid, in_ready); end
        in_valid = 1'b1; in_c = 8'd100; in_a = 8'd1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_b !== 8'd99) begin errors++; $display("FAIL rmid_first got vld %b b %0d want 1 99", out_valid, out_b); end
    endtask

    task automatic test_saturate();
        int pops;
        do_reset();
        s_out_ready = 1'b1; s_in_valid = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            s_in_c = 8'($urandom); s_in_a = 8'($urandom);
            tick();
            if (k == 20) s_in_valid = 1'b0;
            pops = (k - 1 > 20) ? 20 : k - 1;
            checks++;
            if (s_done_cnt !== 4'((pops > 15) ? 15 : pops)) begin
                errors++; $display("FAIL sat[%0d] got %0d want %0d", k, s_done_cnt, (pops > 15) ? 15 : pops);
            end
        end
        s_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
